// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: machine-cycle phases, fetch FSM states and the
// OPR codes of the two-byte instructions. Also used by the ALU and decoder.
package instr_sequencer_pkg;

  // Eight clock phases per machine cycle
  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  // Fetch FSM: opcode cycle and operand cycle
  typedef enum logic {
    ST_FETCH1 = 1'b0,
    ST_FETCH2 = 1'b1
  } fetch_state_e;

  // OPR nibbles of instructions that carry an operand byte
  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;  // OPR 2 with OPA[0]=0; OPA[0]=1 is SRC
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;

  localparam int PC_W = 12;

  // True when the opcode is followed by an operand byte
  function automatic logic is_two_byte(input logic [7:0] op);
    logic res;
    case (op[7:4])
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: res = 1'b1;
      OPR_FIM:                            res = ~op[0];
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Phase successor, X3 wraps to A1
  function automatic phase_e next_phase(input phase_e ph);
    return phase_e'(ph + 3'd1);
  endfunction

endpackage

// File: rtl/instr_sequencer_pc.sv
// 12-bit program counter: reset value, load, increment (wraps FFF->000), hold.
module program_counter #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [11:0] load_addr_i,
  output logic [11:0] pc_o
);

  logic [11:0] pc_q;
  logic [11:0] pc_d;

  // Load takes priority over increment; hold freezes the counter
  always_comb begin
    pc_d = pc_q;
    if (!hold_i) begin
      if (load_i)     pc_d = load_addr_i;
      else if (inc_i) pc_d = pc_q + 12'd1;
    end
  end

  // Counter register, reset overrides hold
  always_ff @(posedge clk) begin
    if (rst) pc_q <= PC_RESET;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: phase counter, one/two-byte fetch FSM, instruction
// and operand registers, execute strobe and jump handling.
module instr_sequencer #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [7:0]  romData,
  input  logic        pcLoad,
  input  logic [11:0] pcLoadAddr,
  output logic [11:0] romAddr,
  output logic [2:0]  phase,
  output logic        syncOut,
  output logic [3:0]  aluOp,
  output logic [3:0]  opa,
  output logic [7:0]  secondByte,
  output logic        twoByte,
  output logic        execStrobe
);

  import instr_sequencer_pkg::*;

  phase_e       phase_q, phase_d;
  fetch_state_e state_q, state_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   sec_q, sec_d;
  logic         two_q, two_d;
  // Set by this cycle's execStrobe; arms the jump sample at X3
  logic         ldarm_q, ldarm_d;

  logic at_m2, at_x1, at_x3;
  logic exec_strobe;
  logic pc_inc, pc_load;

  assign at_m2 = (phase_q == PH_M2);
  assign at_x1 = (phase_q == PH_X1);
  assign at_x3 = (phase_q == PH_X3);

  // Instruction completes at X1 of its last byte's cycle
  assign exec_strobe = !rst && !hold && at_x1 &&
                       ((state_q == ST_FETCH2) || !two_q);

  // Each fetched byte advances the PC at M2; a jump replaces it at X3
  assign pc_inc  = at_m2;
  assign pc_load = at_x3 && ldarm_q && pcLoad;

  program_counter #(
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .inc_i       (pc_inc),
    .load_i      (pc_load),
    .load_addr_i (pcLoadAddr),
    .pc_o        (romAddr)
  );

  // Next-state: phase advance, byte latching at M2, FSM step at X3
  always_comb begin
    phase_d = phase_q;
    state_d = state_q;
    ir_d    = ir_q;
    sec_d   = sec_q;
    two_d   = two_q;
    ldarm_d = ldarm_q;
    if (!hold) begin
      phase_d = next_phase(phase_q);
      if (at_m2 && (state_q == ST_FETCH1)) begin
        ir_d  = romData;
        two_d = is_two_byte(romData);
      end
      if (at_m2 && (state_q == ST_FETCH2)) begin
        sec_d = romData;
      end
      if (exec_strobe) begin
        ldarm_d = 1'b1;
      end
      if (at_x3) begin
        ldarm_d = 1'b0;
        if ((state_q == ST_FETCH1) && two_q) state_d = ST_FETCH2;
        else                                 state_d = ST_FETCH1;
      end
    end
  end

  // FSM and instruction registers; reset abandons any partial instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_A1;
      state_q <= ST_FETCH1;
      ir_q    <= 8'h00;
      sec_q   <= 8'h00;
      two_q   <= 1'b0;
      ldarm_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      ir_q    <= ir_d;
      sec_q   <= sec_d;
      two_q   <= two_d;
      ldarm_q <= ldarm_d;
    end
  end

  assign phase      = phase_q;
  assign syncOut    = (phase_q == PH_A1);
  assign aluOp      = ir_q[7:4];
  assign opa        = ir_q[3:0];
  assign secondByte = sec_q;
  assign twoByte    = two_q;
  assign execStrobe = exec_strobe;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_RESET, default 12'h000: program counter value after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port hold, input, 1: stall; freezes all state while high.
REQ-005 SHALL have port romData, input, 8: instruction byte at romAddr, combinational (asynchronous ROM).
REQ-006 SHALL have port pcLoad, input, 1: jump request from the execute side.
REQ-007 SHALL have port pcLoadAddr, input, 12: jump target.
REQ-008 SHALL have port romAddr, output, 12: current PC.
REQ-009 SHALL have port phase, output, 3: machine-cycle phase A1=0, A2, A3, M1, M2, X1, X2, X3=7.
REQ-010 SHALL have port syncOut, output, 1: high when phase==A1.
REQ-011 SHALL have port aluOp, output, 4: OPR nibble (ir[7:4]) to the ALU.
REQ-012 SHALL have port opa, output, 4: OPA nibble (ir[3:0]) to the ALU.
REQ-013 SHALL have port secondByte, output, 8: operand byte of a two-byte instruction.
REQ-014 SHALL have port twoByte, output, 1: current instruction is two-byte.
REQ-015 SHALL have port execStrobe, output, 1: one-cycle pulse when the instruction is complete and ALU result is to be committed.

Function
REQ-016 SHALL advance phase 0..7 by one per clk when hold=0, wrapping 7->0; 8 clocks per machine cycle.
REQ-017 SHALL run FSM states FETCH1 (opcode cycle) and FETCH2 (operand cycle); transitions only at X3->A1.
REQ-018 SHALL in FETCH1 at M2 latch ir<=romData and increment PC.
REQ-019 SHALL classify as two-byte: OPR 1 (JCN), 4 (JUN), 5 (JMS), 7 (ISZ), and OPR 2 with OPA[0]=0 (FIM); OPR 2 with OPA[0]=1 (SRC) and all others are one-byte.
REQ-020 SHALL for a two-byte instruction go FETCH1->FETCH2, latch secondByte<=romData at M2 of FETCH2, increment PC, then return to FETCH1.
REQ-021 SHALL hold aluOp/opa/twoByte stable from the M2 latch until the next FETCH1 M2; secondByte stable from its latch until the next FETCH2 M2.
REQ-022 SHALL assert execStrobe = (phase==X1) && (FETCH1 with one-byte ir, or FETCH2) && !hold; exactly one pulse per instruction.
REQ-023 SHALL sample pcLoad only at phase X3 of a cycle that produced execStrobe; then PC<=pcLoadAddr; at other phases pcLoad is ignored.
REQ-024 SHALL wrap PC 12'hFFF -> 12'h000 on increment.
REQ-025 SHALL freeze phase, state, PC, ir, secondByte while hold=1; outputs keep their values except execStrobe (forced 0).

Reset
REQ-026 SHALL on rst=1 at a clk edge set phase=A1, state=FETCH1, PC=PC_RESET, ir=8'h00 (NOP), secondByte=8'h00, twoByte=0; rst overrides hold.
REQ-027 SHALL drive execStrobe=0 during reset and abandon any partial instruction (no strobe, no PC load) when rst is asserted mid-cycle.

Structure
REQ-028 SHALL place phase encodings A1..X3, FSM state encoding and two-byte OPR constants (JCN, FIM, JUN, JMS, ISZ) in the shared CPU package, reused by the ALU and decoder.
REQ-029 SHALL contain one sub-module program_counter (12-bit register with increment, load, hold, reset to PC_RESET).

Verification
REQ-030 Reset release, ROM[000]=8'hD5 (LDM 5) -> aluOp=D, opa=5 after M2 edge; execStrobe at phase X1 of first cycle; romAddr=001; twoByte=0.
REQ-031 ROM[000]=8'h4A, [001]=8'h23 (JUN), pcLoad=1 with 12'hA23 at X3 -> no strobe in cycle 1; strobe in cycle 2 with secondByte=8'h23; next fetch romAddr=A23.
REQ-032 ROM byte 8'h20 (FIM) -> twoByte=1, two cycles; ROM byte 8'h21 (SRC) -> twoByte=0, strobe in first cycle.
REQ-033 hold=1 for 3 clocks entered at phase A3 -> phase stays 2; machine cycle takes 11 clocks; exactly one execStrobe.
REQ-034 PC_RESET=12'hFFF, one-byte instruction at FFF -> romAddr=000 after M2.
REQ-035 rst asserted at phase X1 of FETCH2 (JMS) -> execStrobe=0 that cycle; next cycle phase=A1, romAddr=PC_RESET, aluOp=0.
